// File: rtl/alu_exec_sequencer.sv
// Execute-button controller for a 16x32 register file and 8-op ALU: debounces the
// button and runs one fetch/read/execute/write-back sequence per press.
module alu_exec_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 4
) (
  input  logic                    clk,
  input  logic                    btn_reset,
  input  logic                    btn_exec,
  input  logic [3+3*ADDR_W-1:0]   instr,
  output logic [ADDR_W-1:0]       rf_raddr_a,
  output logic [ADDR_W-1:0]       rf_raddr_b,
  input  logic [DATA_W-1:0]       rf_rdata_a,
  input  logic [DATA_W-1:0]       rf_rdata_b,
  output logic [2:0]              alu_op,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_result,
  output logic                    rf_we,
  output logic [ADDR_W-1:0]       rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic [DATA_W-1:0]       result,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             exec_count
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef struct packed {
    logic [2:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_READ,
    S_EXEC,
    S_WB,
    S_WAIT_REL
  } state_e;

  // Button path: two-flop synchronizer, then a run-length debouncer
  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trigger;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) level_d = ~level_q;
      else                  cnt_d   = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_exec;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign trigger = level_q & ~level_prev_q;

  // Execution sequencer
  state_e            state_q;
  instr_t            instr_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, res_q, result_q;
  logic              rf_we_q, done_q, busy_q;
  logic [15:0]       exec_count_q;

  always_ff @(posedge clk) begin
    if (btn_reset) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res_q        <= '0;
      result_q     <= '0;
      rf_we_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      exec_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          instr_q <= instr;
          state_q <= S_READ;
        end
        S_READ: begin
          alu_a_q <= rf_rdata_a;
          alu_b_q <= rf_rdata_b;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          // Strobes are registered, so they are raised on the way into WB
          res_q   <= alu_result;
          rf_we_q <= (instr_q.rd != '0);
          done_q  <= 1'b1;
          state_q <= S_WB;
        end
        S_WB: begin
          rf_we_q      <= 1'b0;
          done_q       <= 1'b0;
          result_q     <= res_q;
          exec_count_q <= exec_count_q + 16'd1;
          state_q      <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          if (!level_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Address/op outputs come straight from the instruction latch, so they hold between runs
  assign rf_raddr_a = instr_q.rs;
  assign rf_raddr_b = instr_q.rt;
  assign alu_op     = instr_q.op;
  assign rf_waddr   = instr_q.rd;
  assign rf_wdata   = res_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rf_we      = rf_we_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign result     = result_q;
  assign exec_count = exec_count_q;

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle controller that sits between the switch/button front end and the 16x32 register file + 8-op ALU datapath.
- Debounces the exec button and turns each press into exactly one instruction execution.
- Sequences each execution as read operands → execute → write back, with R0 write suppression.
- Holds the last result for the LED display mux and counts completed executions.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before the debounced button level changes (4 for sim, 1_000_000 on board).
- DATA_W, 32, register/ALU data width.
- ADDR_W, 4, register address width (16 registers).

Ports:
- clk  in  1  system clock, all state on rising edge.
- btn_reset  in  1  synchronous, active-high reset.
- btn_exec  in  1  raw (bouncy, asynchronous) execute button.
- instr  in  15  {op[14:12], rd[11:8], rs[7:4], rt[3:0]} from switches.
- rf_raddr_a  out  4  register file read port A address (rs).
- rf_raddr_b  out  4  register file read port B address (rt).
- rf_rdata_a  in  32  port A data; combinational (asynchronous) read.
- rf_rdata_b  in  32  port B data; combinational read.
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SL, 110 SRL, 111 SLT.
- alu_a  out  32  latched operand A.
- alu_b  out  32  latched operand B.
- alu_result  in  32  combinational ALU output.
- rf_we  out  1  register file write enable.
- rf_waddr  out  4  write address.
- rf_wdata  out  32  write data.
- result  out  32  last executed result, held until the next write-back.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the WB state.
- exec_count  out  16  completed executions; wraps 0xFFFF→0x0000.

Behaviour:
- Reset (btn_reset=1 at a clock edge):
  - State goes to IDLE.
  - Synchronizer flops, debounce counter, debounced level and the instruction/operand/result latches all clear to 0.
  - All outputs are 0 from the next cycle.
  - Reset mid-operation aborts with no write: rf_we is 0 from the cycle after the reset edge.
- Synchronizer: btn_exec passes through 2 flops before the debouncer.
- Debounce:
  - Counter increments while the synchronized value differs from the debounced level; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced level toggles and the counter clears.
- Trigger:
  - trigger = debounced level rising (level=1, previous level=0), one cycle wide.
  - A trigger in any state other than IDLE is ignored.
- FSM, one cycle per state except WAIT_REL. A trigger at cycle T gives:
  - IDLE: on trigger, go to FETCH at T+1.
  - FETCH (T+1): latch instr into instr_q. Only the value sampled here is used; later switch changes have no effect.
  - READ (T+2): rf_raddr_a=instr_q.rs, rf_raddr_b=instr_q.rt (driven from READ onward); latch rf_rdata_a/b into alu_a/alu_b at the end of the cycle.
  - EXEC (T+3): alu_op=instr_q.op; latch alu_result into res_q.
  - WB (T+4):
    - rf_waddr=rd and rf_wdata=res_q.
    - rf_we=1 only if rd≠0; rd=0 gives rf_we=0.
    - result←res_q, done=1, exec_count+1. These happen whether or not rd=0.
  - WAIT_REL (T+5 onward): stay until debounced level is 0, then go to IDLE. A held button therefore produces exactly one execution.
- Outputs outside their states:
  - rf_we is asserted only in WB.
  - alu_op holds instr_q.op outside EXEC.
  - rf_raddr_* hold their last values.
- SLT is signed and shifts use alu_b[4:0]; both are ALU responsibilities, and this block passes operands unmodified.
- Latency: write-back occurs 4 cycles after the trigger, which is 2 + DEBOUNCE_CYCLES + 4 cycles after the first stable raw high.

Test Plan:
- Setup for all cases: DEBOUNCE_CYCLES=4; register file model preloaded Ri=i, R0=0.
1. instr=ADD rd=4 rs=1 rt=2, btn_exec high 20 cycles → exactly one rf_we pulse with waddr=4, wdata=0x00000003; result=3; done one cycle; exec_count=1; busy low after release.
2. btn_exec high 2 cycles then low → no trigger, busy stays 0, exec_count unchanged.
3. instr=ADD rd=0 rs=1 rt=2, press → rf_we never 1; result=3; done pulses; exec_count increments.
4. btn_exec held 100 cycles → one execution only; release, then a second press of SUB rd=5 rs=11 rt=10 → second execution with wdata=1, exec_count=2.
5. Assert btn_reset for one cycle during EXEC → no rf_we; busy=0, result=0, exec_count=0 next cycle.
6. Change instr to OR rd=7 two cycles after the trigger (after FETCH) → write goes to the original rd/op; instr change has no effect.
